// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request port, redirect input and decode handshake.
interface fetch_unit_if;
   logic [31:0] imem_address;
   logic        imem_enable;
   logic        imem_read_write;
   logic [31:0] imem_data_in;
   logic [31:0] imem_data_out;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   modport master (
      output imem_address, imem_enable, imem_read_write, imem_data_in,
      output inst_valid, inst, inst_pc,
      input  imem_data_out, redirect_valid, redirect_pc, inst_ready
   );
   modport slave (
      input  imem_address, imem_enable, imem_read_write, imem_data_in,
      input  inst_valid, inst, inst_pc,
      output imem_data_out, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, 1-cycle-latency memory requests and a 2-entry skid buffer to decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
   input logic        clock,
   input logic        reset_n,
   fetch_unit_if.master bus
);
   logic [31:0] pc, req_pc, addr;
   logic        req_pending, redir, pop, push, issue;
   logic [1:0]  count, slot;
   logic [2:0]  occ;
   logic [63:0] head, tail, incoming;
   always_comb begin
      redir    = reset_n & bus.redirect_valid;
      pop      = (count != 2'd0) & bus.inst_ready;
      push     = req_pending & ~redir;
      // occupancy after this cycle, counting the response still in flight
      occ      = {1'b0, count} + {2'b0, req_pending} - {2'b0, pop};
      issue    = reset_n & (redir | (occ < 3'd2));
      addr     = redir ? {bus.redirect_pc[31:2], 2'b00} : pc;
      slot     = count - {1'b0, pop};
      incoming = {bus.imem_data_out, req_pc};
   end
   assign bus.imem_enable     = issue;
   assign bus.imem_address    = addr;
   assign bus.imem_read_write = 1'b0;
   assign bus.imem_data_in    = '0;
   assign bus.inst_valid      = count != 2'd0;
   assign bus.inst            = head[63:32];
   assign bus.inst_pc         = head[31:0];
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc          <= RESET_PC;
         req_pc      <= '0;
         req_pending <= 1'b0;
         count       <= '0;
         head        <= '0;
         tail        <= '0;
      end else begin
         if (issue) begin
            pc     <= addr + 32'd4;
            req_pc <= addr;
         end
         req_pending <= issue;
         if (redir) begin
            count <= '0;
         end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop && count == 2'd2) head <= tail;
            if (push && slot == 2'd0) head <= incoming;
            if (push && slot == 2'd1) tail <= incoming;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch order, backpressure, redirect, wrap and reset.
module tb_fetch_unit;
   logic clock = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   localparam logic [31:0] B = 32'h0100_0100;
   fetch_unit_if bus ();
   fetch_unit dut (.clock(clock), .reset_n(reset_n), .bus(bus));
   always #5 clock = ~clock;
   // memory preloaded with each word equal to its own address
   always @(posedge clock) if (bus.imem_enable) bus.imem_data_out <= bus.imem_address;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
      @(negedge clock);
      bus.inst_ready     = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      #1;
   endtask
   initial begin
      reset_n            = 1'b0;
      bus.inst_ready     = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      repeat (2) @(negedge clock);
      #1;
      chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("rst_inst", bus.inst, 32'd0);
      chk("rst_pc", bus.inst_pc, 32'd0);
      chk("rst_en", {31'b0, bus.imem_enable}, 32'd0);
      chk("rst_addr", bus.imem_address, 32'h0100_0000);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("c0_en", {31'b0, bus.imem_enable}, 32'd1);
      chk("c0_addr", bus.imem_address, 32'h0100_0000);
      chk("c0_valid", {31'b0, bus.inst_valid}, 32'd0);
      step(1, 0, 0);
      chk("c1_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("c1_addr", bus.imem_address, 32'h0100_0004);
      step(1, 0, 0);
      chk("c2_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("c2_pc", bus.inst_pc, 32'h0100_0000);
      chk("c2_inst", bus.inst, 32'h0100_0000);
      step(1, 0, 0);
      chk("c3_pc", bus.inst_pc, 32'h0100_0004);
      // redirect while the response for 0x0100000C is returning
      step(1, 1, B);
      chk("c4_pc", bus.inst_pc, 32'h0100_0008);
      chk("c4_addr", bus.imem_address, B);
      chk("c4_en", {31'b0, bus.imem_enable}, 32'd1);
      step(1, 0, 0);
      chk("c5_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("c5_addr", bus.imem_address, B + 32'd4);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0);
         chk("run_valid", {31'b0, bus.inst_valid}, 32'd1);
         chk("run_pc", bus.inst_pc, B + 32'(4 * i));
         chk("run_inst", bus.inst, B + 32'(4 * i));
         chk("run_en", {31'b0, bus.imem_enable}, 32'd1);
      end
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0);
         chk("stall_valid", {31'b0, bus.inst_valid}, 32'd1);
         chk("stall_pc", bus.inst_pc, B + 32'h10);
         chk("stall_inst", bus.inst, B + 32'h10);
         chk("stall_en", {31'b0, bus.imem_enable}, 32'd0);
      end
      step(1, 0, 0);
      chk("resume_pc", bus.inst_pc, B + 32'h10);
      chk("resume_en", {31'b0, bus.imem_enable}, 32'd1);
      for (int i = 1; i < 4; i++) begin
         step(1, 0, 0);
         chk("after_pc", bus.inst_pc, B + 32'h10 + 32'(4 * i));
      end
      step(0, 0, 0);
      chk("fill_pc", bus.inst_pc, B + 32'h20);
      chk("fill_en", {31'b0, bus.imem_enable}, 32'd0);
      // buffer now full: redirect together with a pop
      step(1, 1, 32'h0100_0202);
      chk("full_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("full_pc", bus.inst_pc, B + 32'h20);
      chk("full_addr", bus.imem_address, 32'h0100_0200);
      chk("full_en", {31'b0, bus.imem_enable}, 32'd1);
      step(1, 0, 0);
      chk("flush_valid", {31'b0, bus.inst_valid}, 32'd0);
      step(1, 0, 0);
      chk("tgt_pc", bus.inst_pc, 32'h0100_0200);
      step(1, 0, 0);
      chk("tgt_pc2", bus.inst_pc, 32'h0100_0204);
      step(1, 1, 32'hFFFF_FFFC);
      chk("wrap_addr0", bus.imem_address, 32'hFFFF_FFFC);
      step(1, 0, 0);
      chk("wrap_addr1", bus.imem_address, 32'h0000_0000);
      chk("wrap_en", {31'b0, bus.imem_enable}, 32'd1);
      chk("wrap_valid", {31'b0, bus.inst_valid}, 32'd0);
      step(1, 0, 0);
      chk("wrap_pc0", bus.inst_pc, 32'hFFFF_FFFC);
      chk("wrap_addr2", bus.imem_address, 32'h0000_0004);
      step(1, 0, 0);
      chk("wrap_pc1", bus.inst_pc, 32'h0000_0000);
      chk("wrap_inst1", bus.inst, 32'h0000_0000);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("mid_rst_en", {31'b0, bus.imem_enable}, 32'd0);
      chk("mid_rst_addr", bus.imem_address, 32'h0100_0000);
      chk("mid_rst_pc", bus.inst_pc, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("re_c0_addr", bus.imem_address, 32'h0100_0000);
      chk("re_c0_en", {31'b0, bus.imem_enable}, 32'd1);
      step(1, 0, 0);
      chk("re_c1_valid", {31'b0, bus.inst_valid}, 32'd0);
      step(1, 0, 0);
      chk("re_c2_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("re_c2_pc", bus.inst_pc, 32'h0100_0000);
      step(1, 0, 0);
      chk("re_c3_pc", bus.inst_pc, 32'h0100_0004);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
